// File: rtl/uart_rx_8n1_if.sv
// Receive-side link between the 8N1 UART receiver and its consumer.
// The receiver owns the master modport; the consumer or line driver holds slave.
interface uart_rx_8n1_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output rx_busy
    );

    modport slave (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronises rx, samples each bit at mid-bit, strobes good
// bytes on rx_valid and bad stop bits on frame_err.
module uart_rx_8n1 #(
    parameter int CLK_FREQ  = 12000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_8n1_if.master bus
);

    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int          HALF_BIT     = CLKS_PER_BIT / 2;
    localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST    = 16'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t      state, state_n;
    logic        rx_meta, rx_s;
    logic [15:0] clk_count, clk_count_n;
    logic [2:0]  bit_index, bit_index_n;
    logic [7:0]  shift, shift_n;
    logic [7:0]  rx_data, rx_data_n;
    logic        rx_valid, rx_valid_n;
    logic        frame_err, frame_err_n;
    logic        rx_busy;

    // Sync flops reset high so a released reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            clk_count <= '0;
            bit_index <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            rx_meta   <= bus.rx;
            rx_s      <= rx_meta;
            state     <= state_n;
            clk_count <= clk_count_n;
            bit_index <= bit_index_n;
            shift     <= shift_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            frame_err <= frame_err_n;
            rx_busy   <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n     = state;
        clk_count_n = clk_count;
        bit_index_n = bit_index;
        shift_n     = shift;
        rx_data_n   = rx_data;
        rx_valid_n  = 1'b0;
        frame_err_n = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n     = START;
                    clk_count_n = '0;
                end
            end
            // A start bit still low at its midpoint is real; otherwise a glitch.
            START: begin
                if (clk_count == HALF_LAST) begin
                    clk_count_n = '0;
                    if (!rx_s) begin
                        state_n     = DATA;
                        bit_index_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    clk_count_n = clk_count + 16'd1;
                end
            end
            DATA: begin
                if (clk_count == BIT_LAST) begin
                    clk_count_n        = '0;
                    shift_n[bit_index] = rx_s;
                    if (bit_index == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_index_n = bit_index + 3'd1;
                    end
                end else begin
                    clk_count_n = clk_count + 16'd1;
                end
            end
            // Leaving at mid-stop lets a back-to-back start edge be caught.
            STOP: begin
                if (clk_count == BIT_LAST) begin
                    clk_count_n = '0;
                    if (rx_s) begin
                        rx_data_n  = shift;
                        rx_valid_n = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = BREAK;
                    end
                end else begin
                    clk_count_n = clk_count + 16'd1;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.rx_data   = rx_data;
    assign bus.rx_valid  = rx_valid;
    assign bus.frame_err = frame_err;
    assign bus.rx_busy   = rx_busy;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1, run with a scaled clock so a bit is 100 cycles
// (half bit 50); glitch and latency figures scale from the 1250-cycle default.
module tb_uart_rx_8n1;

    localparam int CLK_FREQ  = 960000;
    localparam int BAUD_RATE = 9600;
    localparam int CPB       = 100;
    localparam int HALF      = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_8n1_if bus ();

    uart_rx_8n1 #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int start_cycle = 0;
    int valid_cnt   = 0;
    int ferr_cnt    = 0;
    int both_cnt    = 0;
    int busy_cnt    = 0;
    logic [7:0] valid_q[$];
    int         valid_cyc[$];

    always @(posedge clk) cycle <= cycle + 1;

    // Passive strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            valid_cnt++;
            valid_q.push_back(bus.rx_data);
            valid_cyc.push_back(cycle);
        end
        if (bus.frame_err === 1'b1) ferr_cnt++;
        if (bus.rx_valid === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
        if (bus.rx_busy === 1'b1) busy_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Sends one frame LSB first; the line is left at the stop-bit level.
    task automatic applyStimulus(input logic [7:0] data, input int period,
                                 input logic stop_bit);
        bus.rx      = 1'b0;
        start_cycle = cycle;
        repeat (period) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = data[i];
            repeat (period) @(negedge clk);
        end
        bus.rx = stop_bit;
        repeat (period) @(negedge clk);
    endtask

    task automatic idleLine(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] qAt(input int i);
        return (i < valid_q.size()) ? valid_q[i] : 8'hxx;
    endfunction

    int vb, fb, qb, bb, lat, t0;
    int periods[3] = '{100, 102, 98};

    initial begin
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            bus.rx = i[0];
            @(negedge clk);
        end
        checkOutput("reset_rx_data", bus.rx_data, 8'h00);
        checkOutput("reset_rx_valid", bus.rx_valid, 1'b0);
        checkOutput("reset_frame_err", bus.frame_err, 1'b0);
        checkOutput("reset_rx_busy", bus.rx_busy, 1'b0);
        checkOutput("reset_no_strobes", valid_cnt + ferr_cnt, 0);
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("post_reset_busy", bus.rx_busy, 1'b0);
        checkOutput("post_reset_no_strobes", valid_cnt + ferr_cnt, 0);

        vb = valid_cnt; fb = ferr_cnt; qb = valid_q.size();
        applyStimulus(8'hA5, CPB, 1'b1);
        t0 = start_cycle;
        idleLine(20);
        checkOutput("a5_valid_count", valid_cnt - vb, 1);
        checkOutput("a5_rx_data", bus.rx_data, 8'hA5);
        checkOutput("a5_strobe_data", qAt(qb), 8'hA5);
        checkOutput("a5_frame_err", ferr_cnt - fb, 0);
        lat = (qb < valid_cyc.size()) ? valid_cyc[qb] - t0 : -1;
        $display("[TB] start-to-strobe latency %0d cycles", lat);
        checkOutput("a5_latency_window",
                    (lat >= 2 + HALF + 9 * CPB + 1 - 1 && lat <= 2 + HALF + 9 * CPB + 1 + 1), 1);

        foreach (periods[p]) begin
            vb = valid_cnt; fb = ferr_cnt; qb = valid_q.size();
            applyStimulus(8'h00, periods[p], 1'b1);
            applyStimulus(8'hFF, periods[p], 1'b1);
            idleLine(20);
            checkOutput($sformatf("b2b_p%0d_count", periods[p]), valid_cnt - vb, 2);
            checkOutput($sformatf("b2b_p%0d_first", periods[p]), qAt(qb), 8'h00);
            checkOutput($sformatf("b2b_p%0d_second", periods[p]), qAt(qb + 1), 8'hFF);
            checkOutput($sformatf("b2b_p%0d_ferr", periods[p]), ferr_cnt - fb, 0);
        end

        vb = valid_cnt; fb = ferr_cnt; bb = busy_cnt;
        bus.rx = 1'b0;
        repeat (24) @(negedge clk);
        idleLine(200);
        checkOutput("glitch_no_valid", valid_cnt - vb, 0);
        checkOutput("glitch_no_ferr", ferr_cnt - fb, 0);
        $display("[TB] glitch busy cycles %0d", busy_cnt - bb);
        checkOutput("glitch_busy_window",
                    (busy_cnt - bb >= HALF - 2 && busy_cnt - bb <= HALF + 2), 1);

        vb = valid_cnt;
        applyStimulus(8'h3C, CPB, 1'b1);
        idleLine(20);
        checkOutput("3c_valid_count", valid_cnt - vb, 1);
        checkOutput("3c_rx_data", bus.rx_data, 8'h3C);
        vb = valid_cnt; fb = ferr_cnt;
        applyStimulus(8'h77, CPB, 1'b0);
        repeat (5000) @(negedge clk);
        checkOutput("badstop_ferr_count", ferr_cnt - fb, 1);
        checkOutput("badstop_no_valid", valid_cnt - vb, 0);
        checkOutput("badstop_rx_data_held", bus.rx_data, 8'h3C);
        checkOutput("break_busy", bus.rx_busy, 1'b1);
        idleLine(CPB);
        checkOutput("break_released_busy", bus.rx_busy, 1'b0);
        applyStimulus(8'h81, CPB, 1'b1);
        idleLine(20);
        checkOutput("81_valid_count", valid_cnt - vb, 1);
        checkOutput("81_rx_data", bus.rx_data, 8'h81);
        checkOutput("81_ferr_unchanged", ferr_cnt - fb, 1);

        vb = valid_cnt; fb = ferr_cnt;
        fork
            applyStimulus(8'hFB, CPB, 1'b1);
            begin
                repeat (5 * CPB + 50) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        idleLine(20);
        checkOutput("midreset_no_valid", valid_cnt - vb, 0);
        checkOutput("midreset_no_ferr", ferr_cnt - fb, 0);
        checkOutput("midreset_rx_data_cleared", bus.rx_data, 8'h00);
        applyStimulus(8'h5A, CPB, 1'b1);
        idleLine(20);
        checkOutput("5a_valid_count", valid_cnt - vb, 1);
        checkOutput("5a_rx_data", bus.rx_data, 8'h5A);

        checkOutput("never_valid_and_ferr", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
